uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
UART transmitter that complements the existing receiver path.
- Bytes are pushed into an internal FIFO through a valid/ready interface. The bus side of the UART/AHB wrapper does the push.
- The block serialises each byte onto o_tx as an 8-bit frame: start bit, data LSB first, optional parity, then 1 or 2 stop bits.
- Bit timing comes from the existing baud-rate generator's 16x oversample tick.
- The block sits beside the receiver inside the UART/AHB wrapper. The block's own o_tx is the line the receiver loops back from in system tests.

Parameters:
FIFO_DEPTH, 16, number of byte entries in the TX FIFO; must be a power of 2, minimum 2
OVERSAMPLE, 16, number of i_tick pulses per bit period

Ports:
HCLK  input  1  system clock
HRESETn  input  1  asynchronous active-low reset
i_enable  input  1  transmitter enable; when low, no new frame starts
i_tick  input  1  single-HCLK oversample strobe from the baud generator
i_data  input  8  byte to enqueue
i_valid  input  1  push request for i_data
o_ready  output  1  FIFO can accept a byte (equals !o_fifo_full)
i_parity_en  input  1  add a parity bit to the frame
i_parity_odd  input  1  1 = odd parity, 0 = even parity
i_two_stop  input  1  1 = two stop bits, 0 = one stop bit
o_tx  output  1  serial line, idle high
o_busy  output  1  a frame is in progress
o_fifo_empty  output  1  FIFO holds no bytes
o_fifo_full  output  1  FIFO holds FIFO_DEPTH bytes
o_done  output  1  one-HCLK pulse when the final stop bit completes

Behaviour:
- Reset (async, HRESETn=0), effective immediately:
  - outputs: o_tx=1, o_busy=0, o_done=0, o_fifo_empty=1, o_fifo_full=0, o_ready=1
  - internal: FSM=IDLE, FIFO pointers and count cleared
  - reset during a frame aborts the frame; o_tx returns high with no glitch low
- FIFO:
  - push when i_valid && o_ready; a push while full is dropped and nothing changes
  - pop happens only inside the FSM at frame start
  - push and pop in the same cycle: count is unchanged, both take effect
  - pointers are log2(FIFO_DEPTH) bits wide and wrap; count is log2(FIFO_DEPTH)+1 bits
  - full/empty flags are registered and exact in the cycle after the update
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - All state advances happen only on HCLK cycles where i_tick=1.
  - tick_cnt counts 0..OVERSAMPLE-1 inside each bit.
- IDLE:
  - o_tx=1, o_busy=0
  - on i_tick with i_enable=1 and FIFO not empty: pop the byte into the shift register
  - latch i_parity_en, i_parity_odd, i_two_stop for the whole frame
  - go to START with tick_cnt=0; o_tx=0 and o_busy=1 from the next HCLK edge
- START: o_tx=0; at the tick where tick_cnt=OVERSAMPLE-1, go to DATA with bit index 0.
- DATA:
  - o_tx = shift[0]; shift right each bit; 8 bits
  - after bit 7 completes, go to PARITY if parity is enabled, else to STOP
- PARITY:
  - o_tx = ^data XOR parity_odd, i.e. the bit makes the total number of 1s even (even mode) or odd (odd mode)
  - parity is computed at pop time
- STOP:
  - o_tx=1 for OVERSAMPLE ticks, or 2*OVERSAMPLE ticks when two stop bits are latched
  - on the final stop tick: o_done=1 for that one cycle
  - then, if i_enable=1 and FIFO not empty: pop immediately and go to START, giving back-to-back frames with no idle gap
  - otherwise go to IDLE with o_busy=0
- Frame length is (1+8+P+S)*OVERSAMPLE ticks, where P is 0 or 1 (parity) and S is 1 or 2 (stop bits).
- i_enable deasserted mid-frame: the current frame completes normally; no further pop follows.
- Config inputs changing mid-frame have no effect until the next frame.
- i_tick asserted while in IDLE with the FIFO empty: no action.

Decomposition:
- Shared package uart_pkg:
  - FSM state enum (IDLE/START/DATA/PARITY/STOP)
  - OVERSAMPLE default, data width 8
  - parity mode constants, reused by the receiver
- Sub-module: uart_sync_fifo, a parameterised byte FIFO with push/pop/full/empty/count. It must match the interface of the existing fifo block so both directions share it.
- FSM, shift register and tick counter stay in uart_tx_fifo.

Test Plan:
1. Push 0xAB, 8N1, i_enable=1 -> o_tx = 0,1,1,0,1,0,1,0,1,1, each bit held exactly 16 ticks; o_done pulses once; o_busy is high for 160 ticks.
2. Push 0xAB with parity enabled -> even mode: parity bit 1; odd mode: parity bit 0. i_two_stop=1 gives a 32-tick high stop period; total frame 192 ticks.
3. With i_enable=0, push 17 bytes 0x00..0x10 (FIFO_DEPTH=16) -> o_fifo_full=1 and o_ready=0 after 16 pushes; the 17th byte is dropped. Then enable -> 16 back-to-back frames 0x00..0x0F with no idle tick between stop and start; o_fifo_empty=1 after the last pop.
4. Push while a frame is in progress at the exact cycle of the pop, FIFO count 1 -> count stays 1; the next frame carries the new byte.
5. Assert HRESETn=0 during DATA bit 3 -> o_tx=1 and o_busy=0 immediately; FIFO empty. After release, no frame is sent until a new push.
6. Deassert i_enable during DATA with 2 bytes queued -> the current frame finishes with o_done pulsing; line stays high; the FIFO still holds 1 byte.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART transmit and receive paths
package uart_pkg;
  localparam int DATA_W = 8;
  localparam int OVERSAMPLE_DEF = 16;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;
  typedef enum logic {PARITY_EVEN = 1'b0, PARITY_ODD = 1'b1} parity_e;
  function automatic logic parity_bit(input logic [DATA_W-1:0] d, input parity_e mode);
    return (^d) ^ (mode == PARITY_ODD);
  endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: power-of-two synchronous FIFO with registered full/empty flags
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count_d;
  logic do_push, do_pop;
  assign do_push = i_push && !o_full;
  assign do_pop = i_pop && !o_empty;
  assign count_d = o_count + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign o_data = mem[rd_ptr];
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      o_count <= '0;
      o_full <= 1'b0;
      o_empty <= 1'b1;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      o_count <= count_d;
      o_full <= count_d == (AW+1)'(DEPTH);
      o_empty <= count_d == '0;
    end
  always_ff @(posedge HCLK)
    if (do_push) mem[wr_ptr] <= i_data;
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter, start/8 data/optional parity/1-2 stop bits
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              i_enable,
  input  logic              i_tick,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_parity_en,
  input  logic              i_parity_odd,
  input  logic              i_two_stop,
  output logic              o_tx,
  output logic              o_busy,
  output logic              o_fifo_empty,
  output logic              o_fifo_full,
  output logic              o_done
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  uart_state_e state, state_d;
  logic [TW-1:0] tick_cnt, tick_d;
  logic [2:0] bit_idx, bit_d;
  logic [DATA_W-1:0] shift, shift_d, fifo_data;
  logic [CW-1:0] fifo_count;
  logic par_q, par_d, pe_q, pe_d, ts_q, ts_d, tx_d, done_d, pop, start_ok, last_tick;
  assign o_ready = !o_fifo_full;
  assign o_busy = state != IDLE;
  assign start_ok = i_enable && fifo_count != '0;
  assign last_tick = tick_cnt == TW'(OVERSAMPLE - 1);
  uart_sync_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(DATA_W)) u_fifo (
    .HCLK(HCLK),
    .HRESETn(HRESETn),
    .i_push(i_valid),
    .i_data(i_data),
    .i_pop(pop),
    .o_data(fifo_data),
    .o_full(o_fifo_full),
    .o_empty(o_fifo_empty),
    .o_count(fifo_count)
  );
  always_comb begin
    state_d = state;
    tick_d = tick_cnt;
    bit_d = bit_idx;
    shift_d = shift;
    par_d = par_q;
    pe_d = pe_q;
    ts_d = ts_q;
    pop = 1'b0;
    done_d = 1'b0;
    if (i_tick && state != IDLE) tick_d = last_tick ? '0 : tick_cnt + 1'b1;
    if (i_tick)
      case (state)
        IDLE: pop = start_ok;
        START: if (last_tick) begin
          state_d = DATA;
          bit_d = '0;
        end
        DATA: if (last_tick) begin
          shift_d = shift >> 1;
          bit_d = bit_idx + 1'b1;
          if (bit_idx == 3'(DATA_W - 1)) begin
            state_d = pe_q ? PARITY : STOP;
            bit_d = '0;
          end
        end
        PARITY: if (last_tick) begin
          state_d = STOP;
          bit_d = '0;
        end
        STOP: if (last_tick) begin
          bit_d = bit_idx + 1'b1;
          // bit_idx counts stop bits here; the last one ends the frame
          if (bit_idx[0] == ts_q) begin
            done_d = 1'b1;
            state_d = IDLE;
            pop = start_ok;
          end
        end
        default: state_d = IDLE;
      endcase
    if (pop) begin
      state_d = START;
      tick_d = '0;
      bit_d = '0;
      shift_d = fifo_data;
      par_d = parity_bit(fifo_data, parity_e'(i_parity_odd));
      pe_d = i_parity_en;
      ts_d = i_two_stop;
    end
    tx_d = (state_d == START) ? 1'b0 : (state_d == DATA) ? shift_d[0] : (state_d == PARITY) ? par_d : 1'b1;
  end
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state <= IDLE;
      tick_cnt <= '0;
      bit_idx <= '0;
      shift <= '0;
      par_q <= 1'b0;
      pe_q <= 1'b0;
      ts_q <= 1'b0;
      o_tx <= 1'b1;
      o_done <= 1'b0;
    end else begin
      state <= state_d;
      tick_cnt <= tick_d;
      bit_idx <= bit_d;
      shift <= shift_d;
      par_q <= par_d;
      pe_q <= pe_d;
      ts_q <= ts_d;
      o_tx <= tx_d;
      o_done <= done_d;
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: vector table, directed corner sequences and a randomized line-level model check
module tb_uart_tx_fifo;
  localparam int OVS = 16;
  localparam int DEPTH = 16;
  logic HCLK = 1'b0, HRESETn = 1'b0, i_enable = 1'b0, i_tick = 1'b0, i_valid = 1'b0;
  logic i_parity_en = 1'b0, i_parity_odd = 1'b0, i_two_stop = 1'b0;
  logic [7:0] i_data = 8'h00;
  logic o_ready, o_tx, o_busy, o_fifo_empty, o_fifo_full, o_done;
  int n_vec = 0, n_err = 0, done_seen = 0;
  logic [7:0] mq[$];
  bit lq[$];
  bit m_busy = 1'b0, m_tx = 1'b1;
  int m_lvl = 0;
  typedef struct {
    logic [7:0] d;
    logic pe, po, ts;
    int ticks;
    logic [11:0] bits;
  } vec_t;
  vec_t vt[8];

  uart_tx_fifo #(.FIFO_DEPTH(DEPTH), .OVERSAMPLE(OVS)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .i_enable(i_enable), .i_tick(i_tick),
    .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready),
    .i_parity_en(i_parity_en), .i_parity_odd(i_parity_odd), .i_two_stop(i_two_stop),
    .o_tx(o_tx), .o_busy(o_busy), .o_fifo_empty(o_fifo_empty), .o_fifo_full(o_fifo_full),
    .o_done(o_done)
  );

  always #5 HCLK = ~HCLK;

  initial forever begin
    @(negedge HCLK);
    i_tick = 1'($urandom_range(0, 1));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus the per-tick line levels of the frame in flight
  always @(posedge HCLK or negedge HRESETn) begin
    bit push_ok, dn, p;
    logic [7:0] b;
    bit fr[$];
    if (!HRESETn) begin
      mq.delete();
      lq.delete();
      m_busy = 1'b0;
      m_tx = 1'b1;
      m_lvl = 0;
    end else begin
      push_ok = i_valid && mq.size() < DEPTH;
      dn = 1'b0;
      if (i_tick) begin
        if (m_busy && lq.size() == 0) begin
          dn = 1'b1;
          m_busy = 1'b0;
        end
        if (!m_busy && i_enable && mq.size() != 0) begin
          b = mq.pop_front();
          p = (($countones(b) % 2) == 0) == i_parity_odd;
          fr = {1'b0};
          for (int i = 0; i < 8; i++) fr.push_back(b[i]);
          if (i_parity_en) fr.push_back(p);
          fr.push_back(1'b1);
          if (i_two_stop) fr.push_back(1'b1);
          foreach (fr[i]) repeat (OVS) lq.push_back(fr[i]);
          m_busy = 1'b1;
          m_lvl = 0;
        end
        if (m_busy) begin
          m_tx = lq.pop_front();
          m_lvl++;
        end else m_tx = 1'b1;
      end
      if (push_ok) mq.push_back(i_data);
      #1;
      chk("o_tx", o_tx, m_tx);
      chk("o_busy", o_busy, m_busy);
      chk("o_done", o_done, dn);
      chk("o_fifo_empty", o_fifo_empty, mq.size() == 0);
      chk("o_fifo_full", o_fifo_full, mq.size() == DEPTH);
      chk("o_ready", o_ready, mq.size() != DEPTH);
      if (o_done) done_seen++;
    end
  end

  task automatic push_byte(input logic [7:0] d);
    @(negedge HCLK);
    i_data = d;
    i_valid = 1'b1;
    @(negedge HCLK);
    i_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int c = 0;
    while ((o_busy || (i_enable && !o_fifo_empty)) && c < budget) begin
      @(negedge HCLK);
      c++;
    end
    chk({name, "_timeout"}, c >= budget, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, ticks, d0, busy_cycles;
    bit t;
    logic [11:0] bits;
    vt[0] = '{8'hAB, 1'b0, 1'b0, 1'b0, 160, 12'({1'b1, 8'hAB, 1'b0})};
    vt[1] = '{8'hAB, 1'b1, 1'b0, 1'b0, 176, 12'({1'b1, 1'b1, 8'hAB, 1'b0})};
    vt[2] = '{8'hAB, 1'b1, 1'b1, 1'b0, 176, 12'({1'b1, 1'b0, 8'hAB, 1'b0})};
    vt[3] = '{8'hAB, 1'b1, 1'b0, 1'b1, 192, 12'({2'b11, 1'b1, 8'hAB, 1'b0})};
    vt[4] = '{8'h00, 1'b1, 1'b1, 1'b0, 176, 12'({1'b1, 1'b1, 8'h00, 1'b0})};
    vt[5] = '{8'hFF, 1'b1, 1'b0, 1'b1, 192, 12'({2'b11, 1'b0, 8'hFF, 1'b0})};
    vt[6] = '{8'h5A, 1'b0, 1'b0, 1'b1, 176, 12'({2'b11, 8'h5A, 1'b0})};
    vt[7] = '{8'h80, 1'b1, 1'b1, 1'b0, 176, 12'({1'b1, 1'b0, 8'h80, 1'b0})};
    repeat (3) @(negedge HCLK);
    chk("rst_tx", o_tx, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_empty", o_fifo_empty, 1);
    chk("rst_full", o_fifo_full, 0);
    chk("rst_ready", o_ready, 1);
    HRESETn = 1'b1;
    i_enable = 1'b1;
    // Vector table: single frames with hand-derived bit patterns and lengths
    foreach (vt[v]) begin
      i_parity_en = vt[v].pe;
      i_parity_odd = vt[v].po;
      i_two_stop = vt[v].ts;
      d0 = done_seen;
      push_byte(vt[v].d);
      c = 0;
      while (!o_busy && c < 200) begin
        @(negedge HCLK);
        c++;
      end
      chk($sformatf("vec%0d_start", v), c >= 200, 0);
      ticks = 0;
      bits = '0;
      while (o_busy && ticks < 400) begin
        @(posedge HCLK);
        t = i_tick;
        #1;
        if (t) begin
          ticks++;
          if (ticks % OVS == OVS / 2 && ticks / OVS < 12) bits[ticks / OVS] = o_tx;
        end
      end
      @(negedge HCLK);
      chk($sformatf("vec%0d_ticks", v), ticks, vt[v].ticks);
      chk($sformatf("vec%0d_bits", v), bits, vt[v].bits);
      chk($sformatf("vec%0d_done", v), done_seen - d0, 1);
    end
    // Fill while disabled, overflow by one, then drain back to back
    i_enable = 1'b0;
    i_parity_en = 1'b0;
    i_two_stop = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i == 16) begin
        chk("fill_full", o_fifo_full, 1);
        chk("fill_ready", o_ready, 0);
      end
      push_byte(8'(i));
    end
    chk("fill_count", dut.fifo_count, 16);
    d0 = done_seen;
    i_enable = 1'b1;
    wait_idle(20000, "burst");
    @(negedge HCLK);
    chk("burst_frames", done_seen - d0, 16);
    chk("burst_empty", o_fifo_empty, 1);
    // Push on the exact cycle the queued byte is popped
    push_byte(8'h3C);
    push_byte(8'hC3);
    c = 0;
    @(negedge HCLK);
    #1;
    while (!(m_busy && lq.size() == 0 && i_tick) && c < 2000) begin
      @(negedge HCLK);
      #1;
      c++;
    end
    chk("simul_wait", c >= 2000, 0);
    i_data = 8'h96;
    i_valid = 1'b1;
    @(negedge HCLK);
    i_valid = 1'b0;
    chk("simul_count", dut.fifo_count, 1);
    chk("simul_busy", o_busy, 1);
    wait_idle(2000, "simul");
    // Asynchronous reset in the middle of data bit 3
    push_byte(8'hA5);
    push_byte(8'h77);
    c = 0;
    while (!(m_busy && m_lvl >= 5 * OVS - 11) && c < 2000) begin
      @(negedge HCLK);
      c++;
    end
    chk("rst_mid_wait", c >= 2000, 0);
    HRESETn = 1'b0;
    #1;
    chk("rst_mid_tx", o_tx, 1);
    chk("rst_mid_busy", o_busy, 0);
    chk("rst_mid_empty", o_fifo_empty, 1);
    chk("rst_mid_ready", o_ready, 1);
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    busy_cycles = 0;
    repeat (600) begin
      @(negedge HCLK);
      if (o_busy || !o_tx) busy_cycles++;
    end
    chk("rst_quiet", busy_cycles, 0);
    // Disable mid-frame with two bytes queued
    i_enable = 1'b0;
    push_byte(8'h11);
    push_byte(8'h22);
    d0 = done_seen;
    i_enable = 1'b1;
    c = 0;
    while (!(m_busy && m_lvl >= 3 * OVS) && c < 2000) begin
      @(negedge HCLK);
      c++;
    end
    i_enable = 1'b0;
    wait_idle(2000, "disable");
    repeat (400) @(negedge HCLK);
    chk("disable_done", done_seen - d0, 1);
    chk("disable_tx", o_tx, 1);
    chk("disable_busy", o_busy, 0);
    chk("disable_count", dut.fifo_count, 1);
    i_enable = 1'b1;
    wait_idle(2000, "disable_drain");
    // Randomized traffic, enable and config churn against the model
    repeat (12000) begin
      @(negedge HCLK);
      i_valid = $urandom_range(0, 99) < 3;
      i_data = 8'($urandom);
      if ($urandom_range(0, 399) == 0) i_enable = ~i_enable;
      if ($urandom_range(0, 199) == 0) {i_parity_en, i_parity_odd, i_two_stop} = 3'($urandom);
    end
    i_valid = 1'b0;
    i_enable = 1'b1;
    wait_idle(20000, "rand_drain");
    repeat (4) @(negedge HCLK);
    chk("final_empty", o_fifo_empty, 1);
    chk("final_tx", o_tx, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
